// File: rtl/led_scanner.sv
// Multi-digit 7-segment scan controller with tear-free shadow updates.
// Define LED_SCANNER_LZ_BLANK_EN to blank leading zeros (digit 0 always shown).
module led_scanner #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   disp_data_i,
  input  logic [DIGITS-1:0]     dot_mask_i,
  input  logic [DIGITS-1:0]     digit_mask_i,
  input  logic                  update_req_i,
  output logic                  update_ack_o,
  output logic                  frame_done_o,
  output logic [3:0]            bcd_data_o,
  output logic                  need_dot_o,
  output logic [DIGITS-1:0]     digit_sel_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]            cnt_q, cnt_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     pend_q, pend_d;
  logic [DIGITS-1:0][3:0]   data_q, data_d;
  logic [DIGITS-1:0]        dot_q, dot_d;
  logic [DIGITS-1:0]        mask_q, mask_d;
  logic [3:0]               bcd_q, bcd_d;
  logic                     ndot_q, ndot_d;
  logic [DIGITS-1:0]        sel_q, sel_d;
  logic                     ack_q, fd_q;
  logic [DIGITS-1:0]        supp;
  logic                     tick, wrap, load, vis;

  assign tick = (cnt_q == CNT_MAX);
  assign wrap = tick && (idx_q == IDX_MAX);
  assign load = wrap && (pend_q || update_req_i);
  assign vis  = (BLANK_CYCLES == 0) || (cnt_q >= BLANK);

`ifdef LED_SCANNER_LZ_BLANK_EN
  logic zero;
  // Walk from the most significant digit down; stop before digit 0.
  always_comb begin
    supp = '0;
    zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero = zero && (data_q[i] == 4'd0) && !dot_q[i];
      supp[i] = zero;
    end
  end
`else
  always_comb supp = '0;
`endif

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    if (tick)
      idx_d = wrap ? '0 : idx_q + 1'b1;
    pend_d = pend_q;
    data_d = data_q;
    dot_d  = dot_q;
    mask_d = mask_q;
    if (load) begin
      pend_d = 1'b0;
      data_d = disp_data_i;
      dot_d  = dot_mask_i;
      mask_d = digit_mask_i;
    end else if (update_req_i) begin
      pend_d = 1'b1;
    end
    bcd_d  = data_q[idx_q];
    ndot_d = dot_q[idx_q];
    sel_d  = '1;
    if (vis && mask_q[idx_q] && !supp[idx_q])
      sel_d[idx_q] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pend_q <= 1'b0;
      data_q <= '0;
      dot_q  <= '0;
      mask_q <= '0;
      bcd_q  <= 4'd0;
      ndot_q <= 1'b0;
      sel_q  <= '1;
      ack_q  <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      data_q <= data_d;
      dot_q  <= dot_d;
      mask_q <= mask_d;
      bcd_q  <= bcd_d;
      ndot_q <= ndot_d;
      sel_q  <= sel_d;
      ack_q  <= load;
      fd_q   <= wrap;
    end
  end

  assign update_ack_o = ack_q;
  assign frame_done_o = fd_q;
  assign bcd_data_o   = bcd_q;
  assign need_dot_o   = ndot_q;
  assign digit_sel_o  = sel_q;

endmodule

// File: tb/tb_led_scanner.sv
// Self-checking bench for led_scanner: directed scenarios plus a
// time-indexed reference model compared every cycle.
module tb_led_scanner;

  localparam int DIGITS = 4;
  localparam int SCAN_DIV = 4;
  localparam int BLANK = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] disp_data = '0;
  logic [3:0]  dot_mask = '0;
  logic [3:0]  digit_mask = '0;
  logic        update_req = 1'b0;
  logic        update_ack, frame_done, need_dot;
  logic [3:0]  bcd_data, digit_sel;

  int checks = 0;
  int failures = 0;

  led_scanner #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_data_i(disp_data), .dot_mask_i(dot_mask),
    .digit_mask_i(digit_mask), .update_req_i(update_req),
    .update_ack_o(update_ack), .frame_done_o(frame_done),
    .bcd_data_o(bcd_data), .need_dot_o(need_dot),
    .digit_sel_o(digit_sel)
  );

  always #5 clk = ~clk;

  // Reference model: position in the scan derived from elapsed cycles.
  int          t;
  logic [15:0] m_data;
  logic [3:0]  m_dot, m_mask;
  logic        m_pend;
  logic [3:0]  e_bcd, e_sel;
  logic        e_dot, e_ack, e_fd;
  int          mc, md;
  logic        mwrap, mload;

  assign mc = t % SCAN_DIV;
  assign md = (t / SCAN_DIV) % DIGITS;
  assign mwrap = (mc == SCAN_DIV - 1) && (md == DIGITS - 1);
  assign mload = mwrap && (m_pend || update_req);

  function automatic bit suppressed(int d);
`ifdef LED_SCANNER_LZ_BLANK_EN
    if (d == 0) return 1'b0;
    for (int j = d; j < DIGITS; j++)
      if (m_data[4*j +: 4] != 4'd0 || m_dot[j]) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit lit(int d, int c);
    return (c >= BLANK) && m_mask[d] && !suppressed(d);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t <= 0;
      m_pend <= 1'b0;
      m_data <= '0;
      m_dot <= '0;
      m_mask <= '0;
      e_bcd <= 4'd0;
      e_dot <= 1'b0;
      e_sel <= 4'hF;
      e_ack <= 1'b0;
      e_fd <= 1'b0;
    end else begin
      t <= t + 1;
      e_bcd <= m_data[4*md +: 4];
      e_dot <= m_dot[md];
      e_sel <= lit(md, mc) ? ~(4'b0001 << md) : 4'hF;
      e_fd <= mwrap;
      e_ack <= mload;
      if (mload) begin
        m_data <= disp_data;
        m_dot <= dot_mask;
        m_mask <= digit_mask;
        m_pend <= 1'b0;
      end else if (update_req) begin
        m_pend <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    checks = checks + 1;
    if ({bcd_data, need_dot, digit_sel, update_ack, frame_done} !==
        {e_bcd, e_dot, e_sel, e_ack, e_fd}) begin
      failures = failures + 1;
      $display("FAIL model t=%0t got bcd=%h dot=%b sel=%b ack=%b fd=%b exp bcd=%h dot=%b sel=%b ack=%b fd=%b",
               $time, bcd_data, need_dot, digit_sel, update_ack, frame_done,
               e_bcd, e_dot, e_sel, e_ack, e_fd);
    end
  end

  task automatic wait_fd(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 64);
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL %s frame_done timeout got %b exp 1", name, frame_done);
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dt,
                      input logic [3:0] m, input string name);
    int n = 0;
    disp_data = d;
    dot_mask = dt;
    digit_mask = m;
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
    while (update_ack !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (update_ack !== 1'b1 || frame_done !== 1'b1) begin
      failures++;
      $display("FAIL %s ack/fd got %b%b exp 11", name, update_ack, frame_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bcd_data, need_dot, digit_sel, update_ack, frame_done} !== 11'b0000_0_1111_00) begin
        failures++;
        $display("FAIL reset_hold got %b exp 00000111100",
                 {bcd_data, need_dot, digit_sel, update_ack, frame_done});
      end
    end
    rst = 1'b0;
    repeat (32) begin
      @(negedge clk);
      checks++;
      if (digit_sel !== 4'hF) begin
        failures++;
        $display("FAIL reset_dark got %b exp 1111", digit_sel);
      end
    end
  endtask

  task automatic test_load();
    int low [4] = '{0, 0, 0, 0};
    load(16'h1234, 4'b0010, 4'hF, "load");
    for (int i = 0; i < 16; i++) begin
      int s = i / 4;
      int c = i % 4;
      logic [3:0] es = (c == 0) ? 4'hF : ~(4'b0001 << s);
      @(negedge clk);
      if (digit_sel[s] === 1'b0) low[s]++;
      checks++;
      if (digit_sel !== es || bcd_data !== 4'(4 - s) || need_dot !== (s == 1)) begin
        failures++;
        $display("FAIL load_slot%0d got sel=%b bcd=%h dot=%b exp sel=%b bcd=%h dot=%b",
                 i, digit_sel, bcd_data, need_dot, es, 4'(4 - s), s == 1);
      end
    end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (low[s] != 3) begin
        failures++;
        $display("FAIL load_low%0d got %0d exp 3", s, low[s]);
      end
    end
  endtask

  task automatic test_no_req();
    int last = -1;
    int pulses = 0;
    disp_data = 16'hFFFF;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      checks++;
      if (bcd_data === 4'hF) begin
        failures++;
        $display("FAIL noreq_bcd got %h exp not F", bcd_data);
      end
      if (frame_done === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (i - last != 16) begin
            failures++;
            $display("FAIL noreq_gap got %0d exp 16", i - last);
          end
        end
        last = i;
        pulses++;
      end
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL noreq_frames got %0d exp 3", pulses);
    end
  endtask

  task automatic test_midframe();
    int acks = 0;
    bit seen = 0;
    wait_fd("mid_sync");
    repeat (5) @(negedge clk);
    disp_data = 16'hABCD;
    dot_mask = 4'b0000;
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (update_ack === 1'b1) begin
        acks++;
        seen = 1;
      end
      if (!seen) begin
        checks++;
        if (bcd_data > 4'd4 || bcd_data < 4'd1) begin
          failures++;
          $display("FAIL mid_early got %h exp old 1..4", bcd_data);
        end
      end
    end
    checks++;
    if (acks != 1) begin
      failures++;
      $display("FAIL mid_acks got %0d exp 1", acks);
    end
    wait_fd("wrap_sync");
    repeat (15) @(negedge clk);
    disp_data = 16'h5678;
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
    checks++;
    if (update_ack !== 1'b1) begin
      failures++;
      $display("FAIL wrap_req_ack got %b exp 1", update_ack);
    end
    acks = 0;
    repeat (24) begin
      @(negedge clk);
      if (update_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL wrap_req_second got %0d exp 0", acks);
    end
  endtask

  task automatic test_mask();
    int low0 = 0;
    int low2 = 0;
    load(16'h1234, 4'b0000, 4'b0101, "mask");
    repeat (32) begin
      @(negedge clk);
      if (digit_sel[0] === 1'b0) low0++;
      if (digit_sel[2] === 1'b0) low2++;
      checks++;
      if (digit_sel[1] !== 1'b1 || digit_sel[3] !== 1'b1) begin
        failures++;
        $display("FAIL mask_off got %b exp 1x1x", digit_sel);
      end
    end
    checks++;
    if (low0 != 6 || low2 != 6) begin
      failures++;
      $display("FAIL mask_slots got %0d,%0d exp 6,6", low0, low2);
    end
  endtask

  task automatic lz_frame(input logic [15:0] d, input logic [3:0] ev,
                          input string name);
    int low [4] = '{0, 0, 0, 0};
    load(d, 4'b0000, 4'hF, name);
    repeat (16) begin
      @(negedge clk);
      for (int s = 0; s < 4; s++)
        if (digit_sel[s] === 1'b0) low[s]++;
      if (digit_sel[0] === 1'b0) begin
        checks++;
        if (bcd_data !== d[3:0]) begin
          failures++;
          $display("FAIL %s_d0 got %h exp %h", name, bcd_data, d[3:0]);
        end
      end
    end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (low[s] != (ev[s] ? 3 : 0)) begin
        failures++;
        $display("FAIL %s_lit%0d got %0d exp %0d", name, s, low[s], ev[s] ? 3 : 0);
      end
    end
  endtask

  task automatic test_lz();
`ifdef LED_SCANNER_LZ_BLANK_EN
    lz_frame(16'h0007, 4'b0001, "lz7");
    lz_frame(16'h0000, 4'b0001, "lz0");
`else
    lz_frame(16'h0007, 4'b1111, "lz7");
    lz_frame(16'h0000, 4'b1111, "lz0");
`endif
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    load(16'h9876, 4'b1001, 4'hF, "rmid_load");
    repeat (6) @(negedge clk);
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bcd_data, need_dot, digit_sel, update_ack, frame_done} !== 11'b0000_0_1111_00) begin
      failures++;
      $display("FAIL rmid_immediate got %b exp 00000111100",
               {bcd_data, need_dot, digit_sel, update_ack, frame_done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (update_ack === 1'b1) acks++;
      checks++;
      if (digit_sel !== 4'hF) begin
        failures++;
        $display("FAIL rmid_dark got %b exp 1111", digit_sel);
      end
    end
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL rmid_lost got %0d exp 0", acks);
    end
  endtask

  task automatic test_random();
    repeat (600) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0)
        disp_data = {12'h000, 4'($urandom_range(0, 15))};
      else
        disp_data = 16'($urandom);
      dot_mask = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      digit_mask = 4'($urandom);
      update_req = ($urandom_range(0, 11) == 0);
    end
    update_req = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load();
    test_no_req();
    test_midframe();
    test_mask();
    test_lz();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
